// File: rtl/lc3b_ctrl_pipe_pkg.sv
// Shared LC-3b types for the control-word pipeline: opcodes, the decoded
// control word, stage contents, MEM sequencer states and opcode helpers.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'ha,
        OP_STI  = 4'hb,
        OP_JMP  = 4'hc,
        OP_SHF  = 4'hd,
        OP_LEA  = 4'he,
        OP_TRAP = 4'hf
    } lc3b_opcode;

    // Decoded control word as produced by the control ROM.
    typedef struct packed {
        lc3b_opcode opcode;
        lc3b_reg    dest_register;
        logic       load_regfile;
        logic       load_cc;
        logic       load_hazard;
    } lc3b_control_word;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_ACC1,
        MS_ACC2
    } lc3b_mem_state;

    // How the EX/MEM/WB registers move on the next edge.
    typedef enum logic [1:0] {
        ADV_NORMAL,
        ADV_BUBBLE,
        ADV_FLUSH,
        ADV_HOLD
    } lc3b_adv_mode;

    typedef struct packed {
        lc3b_control_word ctrl;
        logic             valid;
    } lc3b_stage;

    localparam lc3b_stage STAGE_BUBBLE = '0;

    // Any opcode that touches data memory at all.
    function automatic logic is_mem_op(lc3b_opcode op);
        return op inside {OP_LDR, OP_LDB, OP_LDI, OP_TRAP, OP_STR, OP_STB, OP_STI};
    endfunction

    // Two-access indirection through a pointer fetched on the first access.
    function automatic logic is_indirect(lc3b_opcode op);
        return op inside {OP_LDI, OP_STI};
    endfunction

    // First access is a read (STI reads its pointer first).
    function automatic logic first_reads(lc3b_opcode op);
        return op inside {OP_LDR, OP_LDB, OP_LDI, OP_TRAP, OP_STI};
    endfunction

    function automatic logic first_writes(lc3b_opcode op);
        return op inside {OP_STR, OP_STB};
    endfunction

    function automatic logic is_byte_op(lc3b_opcode op);
        return op inside {OP_LDB, OP_STB};
    endfunction

endpackage

// File: rtl/lc3b_ctrl_pipe_if.sv
// Data-memory request bus between the control pipeline and the memory side.
interface lc3b_ctrl_pipe_if;

    logic dmem_read;
    logic dmem_write;
    logic dmem_byte;
    logic dmem_addr_sel;
    logic load_ptr;
    logic dmem_resp;

    modport master (
        output dmem_read,
        output dmem_write,
        output dmem_byte,
        output dmem_addr_sel,
        output load_ptr,
        input  dmem_resp
    );

    modport slave (
        input  dmem_read,
        input  dmem_write,
        input  dmem_byte,
        input  dmem_addr_sel,
        input  load_ptr,
        output dmem_resp
    );

endinterface

// File: rtl/lc3b_ctrl_pipe_mem_seq.sv
// MEM-stage access sequencer: decodes the MEM opcode into data-memory
// requests, walks LDI/STI through their two accesses and raises mem_stall
// until the final access completes.
module lc3b_mem_seq
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  lc3b_opcode mem_opcode,
    input  logic       mem_valid,
    input  logic       dmem_resp,
    output logic       dmem_read,
    output logic       dmem_write,
    output logic       dmem_byte,
    output logic       dmem_addr_sel,
    output logic       load_ptr,
    output logic       mem_stall
);

    lc3b_mem_state state;
    logic          op_mem;
    logic          indirect;
    logic          first_acc;
    logic          second_acc;
    logic          final_acc;

    // Request decode from the current state and the instruction held in MEM.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        dmem_read     = 1'b0;
        dmem_write    = 1'b0;
        dmem_byte     = 1'b0;
        dmem_addr_sel = 1'b0;
        load_ptr      = 1'b0;

        op_mem     = mem_valid & is_mem_op(mem_opcode);
        indirect   = is_indirect(mem_opcode);
        // The first access starts the cycle the op enters MEM, so a same-cycle
        // response gives a zero-wait advance.
        first_acc  = op_mem & (state == MS_IDLE || state == MS_ACC1);
        second_acc = op_mem & (state == MS_ACC2);
        final_acc  = second_acc | (first_acc & ~indirect);

        if (first_acc) begin
            dmem_read  = first_reads(mem_opcode);
            dmem_write = first_writes(mem_opcode);
            load_ptr   = indirect & dmem_resp;
        end
        if (second_acc) begin
            dmem_read     = (mem_opcode == OP_LDI);
            dmem_write    = (mem_opcode == OP_STI);
            dmem_addr_sel = 1'b1;
        end
        dmem_byte = (first_acc | second_acc) & is_byte_op(mem_opcode);
        mem_stall = (first_acc | second_acc) & ~(final_acc & dmem_resp);
    end

    // Access-phase state; a reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            state <= MS_IDLE;
        end else begin
            unique case (state)
                MS_IDLE: begin
                    if (op_mem) begin
                        if (!dmem_resp) state <= MS_ACC1;
                        else if (indirect) state <= MS_ACC2;
                        else state <= MS_IDLE;
                    end
                end
                MS_ACC1: begin
                    if (dmem_resp) state <= indirect ? MS_ACC2 : MS_IDLE;
                end
                MS_ACC2: begin
                    if (dmem_resp) state <= MS_IDLE;
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lc3b_ctrl_pipe.sv
// Control-word pipeline: carries the decoded control word through the EX,
// MEM and WB stage registers, resolving memory stalls, branch flushes and
// load-use hazards in that priority order.
module lc3b_ctrl_pipe
    import lc3b_types::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  lc3b_control_word        id_ctrl,
    input  logic                    id_valid,
    input  lc3b_reg                 id_sr1,
    input  lc3b_reg                 id_sr2,
    input  logic                    id_uses_sr1,
    input  logic                    id_uses_sr2,
    input  logic                    br_taken,
    lc3b_ctrl_pipe_if.master        dmem,
    output lc3b_control_word        ex_ctrl,
    output lc3b_control_word        mem_ctrl,
    output lc3b_control_word        wb_ctrl,
    output logic                    ex_valid,
    output logic                    mem_valid,
    output logic                    wb_valid,
    output logic                    stall_fetch,
    output logic                    flush_id,
    output logic                    wb_we,
    output logic                    wb_load_cc
);

    lc3b_stage    ex_q;
    lc3b_stage    mem_q;
    lc3b_stage    wb_q;
    lc3b_stage    id_stage;
    lc3b_adv_mode adv;
    logic         mem_stall;
    logic         hazard;
    logic         flush;

    lc3b_mem_seq u_mem_seq (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_opcode    (mem_q.ctrl.opcode),
        .mem_valid     (mem_q.valid),
        .dmem_resp     (dmem.dmem_resp),
        .dmem_read     (dmem.dmem_read),
        .dmem_write    (dmem.dmem_write),
        .dmem_byte     (dmem.dmem_byte),
        .dmem_addr_sel (dmem.dmem_addr_sel),
        .load_ptr      (dmem.load_ptr),
        .mem_stall     (mem_stall)
    );

    // Hazard/flush detection and the stage-advance priority decision.
    always_comb begin
        id_stage = STAGE_BUBBLE;
        if (id_valid) begin
            id_stage.ctrl  = id_ctrl;
            id_stage.valid = 1'b1;
        end

        hazard = id_valid & ex_q.valid & ex_q.ctrl.load_hazard &
                 ((id_uses_sr1 & (id_sr1 == ex_q.ctrl.dest_register)) |
                  (id_uses_sr2 & (id_sr2 == ex_q.ctrl.dest_register)));
        flush  = br_taken & mem_q.valid & ~mem_stall;

        if (mem_stall)   adv = ADV_HOLD;
        else if (flush)  adv = ADV_FLUSH;
        else if (hazard) adv = ADV_BUBBLE;
        else             adv = ADV_NORMAL;

        stall_fetch = mem_stall | (adv == ADV_BUBBLE);
        flush_id    = (adv == ADV_FLUSH);
    end

    // EX/MEM/WB stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= STAGE_BUBBLE;
            mem_q <= STAGE_BUBBLE;
            wb_q  <= STAGE_BUBBLE;
        end else begin
            unique case (adv)
                ADV_HOLD: begin
                    ex_q  <= ex_q;
                    mem_q <= mem_q;
                    wb_q  <= wb_q;
                end
                ADV_FLUSH: begin
                    ex_q  <= STAGE_BUBBLE;
                    mem_q <= STAGE_BUBBLE;
                    wb_q  <= mem_q;
                end
                ADV_BUBBLE: begin
                    ex_q  <= STAGE_BUBBLE;
                    mem_q <= ex_q;
                    wb_q  <= mem_q;
                end
                default: begin
                    ex_q  <= id_stage;
                    mem_q <= ex_q;
                    wb_q  <= mem_q;
                end
            endcase
        end
    end

    // WB holds while MEM stalls, so writes are withheld until it moves on;
    // that gives exactly one write per retired instruction.
    assign wb_we      = wb_q.valid & wb_q.ctrl.load_regfile & ~mem_stall;
    assign wb_load_cc = wb_q.valid & wb_q.ctrl.load_cc & ~mem_stall;

    assign ex_ctrl   = ex_q.ctrl;
    assign mem_ctrl  = mem_q.ctrl;
    assign wb_ctrl   = wb_q.ctrl;
    assign ex_valid  = ex_q.valid;
    assign mem_valid = mem_q.valid;
    assign wb_valid  = wb_q.valid;

endmodule
